// File: rtl/wb_stage.sv
// Write-back stage: holds one instruction, waits for the data-SRAM response on loads,
// extends sub-word load data and drives the register-file write port.
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_we,
    input  logic [4:0]  mem_waddr,
    input  logic [31:0] mem_result,
    input  logic        mem_is_load,
    input  logic [2:0]  mem_load_type,
    input  logic [1:0]  mem_addr_lo,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    input  logic        flush,
    output logic        wb_allowin,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALU,
        S_WAIT,
        S_LOADED,
        S_DISCARD
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  load_type_q, load_type_d;
    logic [1:0]  addr_lo_q, addr_lo_d;

    logic        accept;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_value;

    assign wb_allowin = (state_q == S_IDLE) || (state_q == S_ALU) || (state_q == S_LOADED);
    assign accept     = mem_valid && wb_allowin && !flush;

    // Lane selection uses the address bits latched with the load, not the live inputs.
    always_comb begin
        byte_sel   = data_rdata[7:0];
        half_sel   = addr_lo_q[1] ? data_rdata[31:16] : data_rdata[15:0];
        load_value = data_rdata;
        case (addr_lo_q)
            2'd0: byte_sel = data_rdata[7:0];
            2'd1: byte_sel = data_rdata[15:8];
            2'd2: byte_sel = data_rdata[23:16];
            2'd3: byte_sel = data_rdata[31:24];
            default: byte_sel = data_rdata[7:0];
        endcase
        case (load_type_q)
            3'b001:  load_value = {{24{byte_sel[7]}}, byte_sel};
            3'b010:  load_value = {24'b0, byte_sel};
            3'b011:  load_value = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_value = {16'b0, half_sel};
            default: load_value = data_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        load_type_d = load_type_q;
        addr_lo_d   = addr_lo_q;

        case (state_q)
            S_IDLE, S_ALU, S_LOADED: begin
                if (accept) begin
                    state_d     = mem_is_load ? S_WAIT : S_ALU;
                    we_d        = mem_we;
                    waddr_d     = mem_waddr;
                    wdata_d     = mem_result;
                    load_type_d = mem_load_type;
                    addr_lo_d   = mem_addr_lo;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                // A flushed load still owes us one response unless it lands this very cycle.
                if (flush) begin
                    state_d = data_data_ok ? S_IDLE : S_DISCARD;
                end else if (data_data_ok) begin
                    state_d = S_LOADED;
                    wdata_d = load_value;
                end
            end
            S_DISCARD: begin
                if (data_data_ok) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            waddr_q     <= 5'd0;
            wdata_q     <= 32'd0;
            load_type_q <= 3'd0;
            addr_lo_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            load_type_q <= load_type_d;
            addr_lo_q   <= addr_lo_d;
        end
    end

    assign we    = we_q && ((state_q == S_ALU) || (state_q == S_LOADED));
    assign waddr = waddr_q;
    assign wdata = wdata_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, hand-written flush/reset
// sequences and a randomized run against a transaction-level reference model.
module tb_wb_stage;

    typedef struct {
        logic        valid;
        logic        is_load;
        logic        in_we;
        logic [4:0]  in_waddr;
        logic [31:0] result;
        logic [2:0]  ltype;
        logic [1:0]  lo;
        logic        dok;
        logic [31:0] rdata;
        logic        flush;
        logic        exp_we;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_wdata;
        logic        exp_allow;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_result;
    logic        mem_is_load;
    logic [2:0]  mem_load_type;
    logic [1:0]  mem_addr_lo;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        flush;
    logic        wb_allowin;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    int compare_count = 0;
    int fail_count    = 0;

    // Reference model: one held instruction plus a count of responses still owed by the bus.
    logic        m_waiting;
    int          m_orphans;
    logic        m_ready;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [2:0]  m_type;
    logic [1:0]  m_lo;

    vec_t vtab [23];

    localparam logic [31:0] RW = 32'h80F1_7F01;

    wb_stage dut (
        .clk           (clk),
        .rst           (rst),
        .mem_valid     (mem_valid),
        .mem_we        (mem_we),
        .mem_waddr     (mem_waddr),
        .mem_result    (mem_result),
        .mem_is_load   (mem_is_load),
        .mem_load_type (mem_load_type),
        .mem_addr_lo   (mem_addr_lo),
        .data_data_ok  (data_data_ok),
        .data_rdata    (data_rdata),
        .flush         (flush),
        .wb_allowin    (wb_allowin),
        .we            (we),
        .waddr         (waddr),
        .wdata         (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compare_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic e_we, input logic [4:0] e_waddr,
                            input logic [31:0] e_wdata, input logic e_allow);
        checkOutput({tag, ".we"},         {31'b0, we},         {31'b0, e_we});
        checkOutput({tag, ".waddr"},      {27'b0, waddr},      {27'b0, e_waddr});
        checkOutput({tag, ".wdata"},      wdata,               e_wdata);
        checkOutput({tag, ".wb_allowin"}, {31'b0, wb_allowin}, {31'b0, e_allow});
    endtask

    task automatic driveIdle();
        mem_valid     = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = 5'd0;
        mem_result    = 32'd0;
        mem_is_load   = 1'b0;
        mem_load_type = 3'd0;
        mem_addr_lo   = 2'd0;
        data_data_ok  = 1'b0;
        data_rdata    = 32'd0;
        flush         = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        @(negedge clk);
        mem_valid     = v.valid;
        mem_we        = v.in_we;
        mem_waddr     = v.in_waddr;
        mem_result    = v.result;
        mem_is_load   = v.is_load;
        mem_load_type = v.ltype;
        mem_addr_lo   = v.lo;
        data_data_ok  = v.dok;
        data_rdata    = v.rdata;
        flush         = v.flush;
        @(posedge clk);
        #1;
        checkAll(tag, v.exp_we, v.exp_waddr, v.exp_wdata, v.exp_allow);
    endtask

    function automatic logic [31:0] refExtract(input logic [2:0] t, input logic [1:0] lo, input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * lo)) & 32'hFF;
        h = (w >> (16 * (lo / 2))) & 32'hFFFF;
        case (t)
            3'd1:    return (b >= 32'd128) ? b - 32'd256 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd4:    return h;
            default: return w;
        endcase
    endfunction

    task automatic modelReset();
        m_waiting = 1'b0;
        m_orphans = 0;
        m_ready   = 1'b0;
        m_we      = 1'b0;
        m_waddr   = 5'd0;
        m_wdata   = 32'd0;
        m_type    = 3'd0;
        m_lo      = 2'd0;
    endtask

    task automatic modelStep(input vec_t vin, output vec_t vout);
        vout = vin;
        if (m_waiting) begin
            m_waiting = 1'b0;
            if (vin.dok && !vin.flush) begin
                m_wdata = refExtract(m_type, m_lo, vin.rdata);
                m_ready = 1'b1;
            end else if (!vin.dok && vin.flush) begin
                m_orphans = m_orphans + 1;
            end else if (!vin.dok) begin
                m_waiting = 1'b1;
            end
        end else if (m_orphans > 0) begin
            if (vin.dok) m_orphans = m_orphans - 1;
        end else if (vin.valid && !vin.flush) begin
            m_we      = vin.in_we;
            m_waddr   = vin.in_waddr;
            m_wdata   = vin.result;
            m_type    = vin.ltype;
            m_lo      = vin.lo;
            m_waiting = vin.is_load;
            m_ready   = !vin.is_load;
        end else begin
            m_ready = 1'b0;
        end
        if (m_waiting || m_orphans > 0) m_ready = 1'b0;
        vout.exp_we    = m_ready && m_we;
        vout.exp_waddr = m_waddr;
        vout.exp_wdata = m_wdata;
        vout.exp_allow = !m_waiting && (m_orphans == 0);
    endtask

    initial begin
        vec_t v;
        vec_t vm;

        //             valid is_ld we    waddr  result        type  lo    dok   rdata          flush  e_we  e_waddr e_wdata        e_allow
        vtab[0]  = '{1'b1, 1'b0, 1'b1, 5'd5,  32'h11,       3'd0, 2'd0, 1'b0, 32'h0,         1'b0,  1'b1, 5'd5,  32'h11,        1'b1};
        vtab[1]  = '{1'b1, 1'b0, 1'b1, 5'd6,  32'h22,       3'd0, 2'd0, 1'b0, 32'h0,         1'b0,  1'b1, 5'd6,  32'h22,        1'b1};
        vtab[2]  = '{1'b1, 1'b0, 1'b1, 5'd7,  32'h33,       3'd0, 2'd0, 1'b0, 32'h0,         1'b0,  1'b1, 5'd7,  32'h33,        1'b1};
        vtab[3]  = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        3'd0, 2'd0, 1'b0, 32'h0,         1'b0,  1'b0, 5'd7,  32'h33,        1'b1};
        vtab[4]  = '{1'b1, 1'b1, 1'b1, 5'd8,  32'h0,        3'd1, 2'd2, 1'b0, 32'h0,         1'b0,  1'b0, 5'd8,  32'h0,         1'b0};
        vtab[5]  = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        3'd0, 2'd0, 1'b1, RW,            1'b0,  1'b1, 5'd8,  32'hFFFF_FFF1, 1'b1};
        vtab[6]  = '{1'b1, 1'b1, 1'b1, 5'd9,  32'h0,        3'd2, 2'd3, 1'b0, 32'h0,         1'b0,  1'b0, 5'd9,  32'h0,         1'b0};
        vtab[7]  = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        3'd0, 2'd0, 1'b1, RW,            1'b0,  1'b1, 5'd9,  32'h0000_0080, 1'b1};
        vtab[8]  = '{1'b1, 1'b1, 1'b1, 5'd10, 32'h0,        3'd3, 2'd0, 1'b0, 32'h0,         1'b0,  1'b0, 5'd10, 32'h0,         1'b0};
        vtab[9]  = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        3'd0, 2'd0, 1'b1, RW,            1'b0,  1'b1, 5'd10, 32'h0000_7F01, 1'b1};
        vtab[10] = '{1'b1, 1'b1, 1'b1, 5'd11, 32'h0,        3'd4, 2'd2, 1'b0, 32'h0,         1'b0,  1'b0, 5'd11, 32'h0,         1'b0};
        vtab[11] = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        3'd0, 2'd0, 1'b1, RW,            1'b0,  1'b1, 5'd11, 32'h0000_80F1, 1'b1};
        vtab[12] = '{1'b1, 1'b1, 1'b1, 5'd12, 32'h0,        3'd0, 2'd0, 1'b0, 32'h0,         1'b0,  1'b0, 5'd12, 32'h0,         1'b0};
        vtab[13] = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        3'd0, 2'd0, 1'b1, RW,            1'b0,  1'b1, 5'd12, RW,            1'b1};
        vtab[14] = '{1'b1, 1'b1, 1'b1, 5'd13, 32'h0,        3'd7, 2'd1, 1'b0, 32'h0,         1'b0,  1'b0, 5'd13, 32'h0,         1'b0};
        vtab[15] = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        3'd0, 2'd0, 1'b1, RW,            1'b0,  1'b1, 5'd13, RW,            1'b1};
        vtab[16] = '{1'b1, 1'b1, 1'b1, 5'd14, 32'h0,        3'd0, 2'd0, 1'b0, 32'h0,         1'b0,  1'b0, 5'd14, 32'h0,         1'b0};
        vtab[17] = '{1'b1, 1'b0, 1'b1, 5'd31, 32'hFFFF,     3'd0, 2'd0, 1'b0, 32'h0,         1'b0,  1'b0, 5'd14, 32'h0,         1'b0};
        vtab[18] = '{1'b1, 1'b0, 1'b1, 5'd31, 32'hFFFF,     3'd0, 2'd0, 1'b0, 32'h0,         1'b0,  1'b0, 5'd14, 32'h0,         1'b0};
        vtab[19] = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        3'd0, 2'd0, 1'b1, 32'h1234_5678, 1'b0,  1'b1, 5'd14, 32'h1234_5678, 1'b1};
        vtab[20] = '{1'b1, 1'b0, 1'b1, 5'd15, 32'hAA,       3'd0, 2'd0, 1'b0, 32'h0,         1'b0,  1'b1, 5'd15, 32'hAA,        1'b1};
        vtab[21] = '{1'b1, 1'b0, 1'b1, 5'd16, 32'hBB,       3'd0, 2'd0, 1'b0, 32'h0,         1'b1,  1'b0, 5'd15, 32'hAA,        1'b1};
        vtab[22] = '{1'b1, 1'b0, 1'b0, 5'd17, 32'h55,       3'd0, 2'd0, 1'b0, 32'h0,         1'b0,  1'b0, 5'd17, 32'h55,        1'b1};

        driveIdle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset", 1'b0, 5'd0, 32'd0, 1'b1);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 23; i++) begin
            applyStimulus(vtab[i], $sformatf("vec%0d", i));
        end

        // Flush one cycle after a load is accepted; its response arrives two cycles later.
        v = '{1'b1, 1'b1, 1'b1, 5'd20, 32'h0, 3'd1, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd20, 32'h0, 1'b0};
        applyStimulus(v, "fw_accept");
        v = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 2'd0, 1'b0, 32'h0, 1'b1, 1'b0, 5'd20, 32'h0, 1'b0};
        applyStimulus(v, "fw_flush");
        v = '{1'b1, 1'b0, 1'b1, 5'd21, 32'h21, 3'd0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd20, 32'h0, 1'b0};
        applyStimulus(v, "fw_discard");
        v = '{1'b1, 1'b0, 1'b1, 5'd21, 32'h21, 3'd0, 2'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd20, 32'h0, 1'b1};
        applyStimulus(v, "fw_orphan");
        v = '{1'b1, 1'b0, 1'b1, 5'd22, 32'h22, 3'd0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1, 5'd22, 32'h22, 1'b1};
        applyStimulus(v, "fw_after");

        // Flush and response in the same cycle; a later stray response must not be swallowed.
        v = '{1'b1, 1'b1, 1'b1, 5'd23, 32'h0, 3'd3, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd23, 32'h0, 1'b0};
        applyStimulus(v, "fs_accept");
        v = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 2'd0, 1'b1, 32'h8000_8000, 1'b1, 1'b0, 5'd23, 32'h0, 1'b1};
        applyStimulus(v, "fs_both");
        v = '{1'b1, 1'b0, 1'b1, 5'd24, 32'h77, 3'd0, 2'd0, 1'b1, 32'h1111_1111, 1'b0, 1'b1, 5'd24, 32'h77, 1'b1};
        applyStimulus(v, "fs_stray");
        v = '{1'b1, 1'b1, 1'b1, 5'd25, 32'h0, 3'd0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd25, 32'h0, 1'b0};
        applyStimulus(v, "fs_load2");
        v = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 2'd0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 5'd25, 32'hCAFE_F00D, 1'b1};
        applyStimulus(v, "fs_data2");

        // Mid-run asynchronous reset while a write is being presented.
        v = '{1'b1, 1'b0, 1'b1, 5'd9, 32'h99, 3'd0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1, 5'd9, 32'h99, 1'b1};
        applyStimulus(v, "pre_reset");
        @(negedge clk);
        driveIdle();
        #2;
        rst = 1'b0;
        #1;
        checkAll("async_reset", 1'b0, 5'd0, 32'd0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        v = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1};
        applyStimulus(v, "post_reset0");
        applyStimulus(v, "post_reset1");

        // Reset while waiting on a load returns the stage to empty and accepting.
        v = '{1'b1, 1'b1, 1'b1, 5'd3, 32'h0, 3'd0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd3, 32'h0, 1'b0};
        applyStimulus(v, "rw_accept");
        @(negedge clk);
        driveIdle();
        rst = 1'b0;
        #1;
        checkAll("rw_reset", 1'b0, 5'd0, 32'd0, 1'b1);
        @(negedge clk);
        rst = 1'b1;

        // Randomized run against the reference model, from a clean reset.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        modelReset();
        for (int i = 0; i < 3000; i++) begin
            v.valid     = ($urandom_range(3) != 0);
            v.is_load   = 1'($urandom_range(1));
            v.in_we     = ($urandom_range(7) != 0);
            v.in_waddr  = 5'($urandom_range(31));
            v.result    = $urandom;
            v.ltype     = 3'($urandom_range(7));
            v.lo        = 2'($urandom_range(3));
            v.dok       = (m_waiting || m_orphans > 0) && ($urandom_range(2) == 0);
            v.rdata     = $urandom;
            v.flush     = ($urandom_range(7) == 0);
            v.exp_we    = 1'b0;
            v.exp_waddr = 5'd0;
            v.exp_wdata = 32'd0;
            v.exp_allow = 1'b0;
            modelStep(v, vm);
            applyStimulus(vm, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage integer pipeline. It sits between the memory stage and the register file and drives the register file's write port (`we`, `waddr`, `wdata`). It holds one instruction, waits for the data-SRAM response on loads, and extracts and extends sub-word load data. It exerts backpressure on the memory stage through `wb_allowin` and handles pipeline flushes without losing track of outstanding bus responses.

## Interface
Parameters:
- none

Ports:
- `clk` input 1: pipeline clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `mem_valid` input 1: memory stage presents an instruction this cycle.
- `mem_we` input 1: instruction writes a GPR.
- `mem_waddr` input 5: destination GPR.
- `mem_result` input 32: ALU result (non-load instructions).
- `mem_is_load` input 1: instruction is a load.
- `mem_load_type` input 3: 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; other codes are treated as LW.
- `mem_addr_lo` input 2: low two bits of the load effective address.
- `data_data_ok` input 1: data SRAM response valid (single-cycle pulse).
- `data_rdata` input 32: data SRAM read word, valid when `data_data_ok`=1.
- `flush` input 1: kill the incoming instruction and any pending load.
- `wb_allowin` output 1: stage can accept from the memory stage this cycle.
- `we` output 1: register-file write enable.
- `waddr` output 5: register-file write address.
- `wdata` output 32: register-file write data.

## Operation
- Accept condition: `accept = mem_valid && wb_allowin && !flush`.
- FSM states:
  - IDLE: empty.
  - ALU: holding a completed non-load.
  - WAIT: load issued, awaiting `data_data_ok`.
  - LOADED: load data captured.
  - DISCARD: flushed load, awaiting its orphan response.
- `wb_allowin` = 1 in IDLE, ALU and LOADED; 0 in WAIT and DISCARD.
- Transitions:
  - IDLE/ALU/LOADED: accept with `mem_is_load`=0 → ALU; accept with `mem_is_load`=1 → WAIT; no accept → IDLE.
  - WAIT: `flush` → DISCARD. If `flush` and `data_data_ok` occur in the same cycle → IDLE and the data is dropped. `data_data_ok` alone → LOADED. Otherwise hold.
  - DISCARD: `data_data_ok` → IDLE; otherwise hold. `flush` has no further effect.
- On accept, latch `mem_we`, `mem_waddr`, `mem_result`, `mem_load_type`, `mem_addr_lo`.
- In WAIT with `data_data_ok`, the extended load value replaces the latched result.
- Load extraction (byte lane selected by `addr_lo`; halfword by `addr_lo[1]`):
  - LB: sign-extend `rdata[8*lo+7:8*lo]`.
  - LBU: zero-extend the same byte.
  - LH: sign-extend `rdata[16*lo[1]+15:16*lo[1]]`.
  - LHU: zero-extend the same halfword.
  - LW: `rdata` unchanged.
- Misalignment is not checked here; the memory stage raises address exceptions and never forwards such loads.
- Outputs:
  - `we` = latched `we` && (state is ALU or LOADED).
  - `waddr`, `wdata` = latched values.
  - `we` is never asserted in IDLE, WAIT or DISCARD.
- Writes to `$0` are passed through unchanged; the register file ignores them.
- `flush` in ALU/LOADED does not suppress the held write, because that instruction has already committed. It only blocks the incoming accept.

## Timing
- Reset (async assert, sync-safe release): state IDLE; `we`=0, `waddr`=0, `wdata`=0, `wb_allowin`=1; latched fields cleared.
- Non-load accepted at edge t: `we`=1 during cycle t..t+1. The register file commits at edge t+1, and its read bypass serves same-cycle readers.
- Load accepted at edge t:
  - Bus contract: `data_data_ok` arrives no earlier than the cycle after acceptance.
  - If `data_data_ok` is sampled at edge t+k (k≥1), then `we`=1 for the cycle following edge t+k.
- Back-to-back non-loads sustain one write per cycle, and `we` stays high.
- A load following an ALU instruction is accepted while the ALU write is presented.
- Exactly one `data_data_ok` is consumed per accepted load, including flushed loads.
- Reset in WAIT or DISCARD abandons the tracking of the outstanding response. The bus is reset by the same `rst`.

## Test plan
- Reset then idle: `rst`=0 mid-run → `we`=0, `waddr`=0, `wdata`=0, `wb_allowin`=1 immediately (asynchronous). They hold after release with `mem_valid`=0.
- ALU burst: three accepts on consecutive cycles (`waddr` 5/6/7, result 0x11/0x22/0x33) → `we`=1 for three consecutive cycles with matching `waddr`/`wdata`, and `wb_allowin` stays 1.
- LB/LBU/LH/LHU/LW with `rdata`=0x80F17F01:
  - LB at `lo`=2 → 0xFFFFFFF1.
  - LBU at `lo`=3 → 0x00000080.
  - LH at `lo`=0 → 0x00007F01.
  - LHU at `lo`=2 → 0x000080F1.
  - LW → 0x80F17F01.
- Load latency: load accepted with `data_data_ok` 3 cycles later → `wb_allowin`=0 for 3 cycles, then `we`=1 one cycle after `data_ok`. A follow-on ALU op is accepted that same cycle.
- Flush in WAIT: flush 1 cycle after load accept, with `data_ok` 2 cycles later → no `we`, `wb_allowin`=0 until `data_ok`, then IDLE with `allowin`=1.
- Simultaneous `flush`+`data_data_ok` in WAIT → IDLE next cycle, no write, and a later unrelated response is not consumed.
